// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and helpers for the thoth-rv32 load/store unit.
//   - access size encodings (byte / half / word)
//   - FSM state encoding used by lsu
//   - address force-alignment and misalignment detection helpers
package lsu_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Clear the low address bits that a naturally aligned access of this size
  // cannot have. The reserved size code is handled like a word.
  function automatic logic [31:0] lsu_align_addr(input logic [1:0] size,
                                                 input logic [31:0] addr);
    logic [31:0] a;
    a = addr;
    case (size)
      LSU_SIZE_B: a = addr;
      LSU_SIZE_H: a = {addr[31:1], 1'b0};
      default:    a = {addr[31:2], 2'b00};
    endcase
    return a;
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic m;
    case (size)
      LSU_SIZE_B: m = 1'b0;
      LSU_SIZE_H: m = addr_lo[0];
      default:    m = (addr_lo != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
// Ports:
//   size_i      access size (LSU_SIZE_B/H/W)
//   unsigned_i  zero-extend loads instead of sign-extend
//   addr_lo_i   addr[1:0] of the (already aligned) access
//   wdata_i     right-aligned store data
//   rdata_i     raw bus read word
//   be_o        byte enables
//   wdata_o     store data replicated across all lanes
//   rdata_o     selected lane, extended to 32 bits
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] lane;

  // Move the addressed lane down to bit 0; halfwords arrive here with
  // addr_lo_i[0]=0, so the same shift serves both sub-word sizes.
  assign lane = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      LSU_SIZE_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      LSU_SIZE_H: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = unsigned_i ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit. Accepts one access from execute, runs a single-beat
// valid/ack bus transaction and returns an extended load result (or a store
// completion) as a one-cycle response pulse.
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   - misaligned H/W accesses skip the bus and respond with rsp_err_o=1
//   undefined - misaligned addresses are force-aligned, rsp_err_o tied 0
// Ports:
//   clk_i, rst_i (async, active-high)
//   req_*  request from execute (valid/ready)
//   bus_*  data bus master side (req/ack)
//   rsp_*  write-back response
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [4:0]  req_rd_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic [4:0]  rsp_rd_o,
  output logic        rsp_err_o
);

  lsu_state_e state_q, state_d;

  logic        ready_q, ready_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;

  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [4:0]  rd_q, rd_d;

  logic [31:0] eff_addr;
  logic        trap_hit;

  logic [1:0]  al_size;
  logic        al_uns;
  logic [1:0]  al_addr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign eff_addr = lsu_align_addr(req_size_i, req_addr_i);

`ifdef LSU_MISALIGN_TRAP_EN
  logic rsp_err_q, rsp_err_d;
  assign trap_hit  = lsu_misaligned(req_size_i, req_addr_i[1:0]);
  assign rsp_err_o = rsp_err_q;
`else
  assign trap_hit  = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  // One aligner serves both directions: in IDLE it shapes the incoming
  // request (be/wdata), afterwards it extracts from the read word using the
  // captured access attributes.
  assign al_size    = (state_q == ST_IDLE) ? req_size_i     : size_q;
  assign al_uns     = (state_q == ST_IDLE) ? req_unsigned_i : uns_q;
  assign al_addr_lo = (state_q == ST_IDLE) ? eff_addr[1:0]  : addr_lo_q;

  lsu_align u_align (
    .size_i     (al_size),
    .unsigned_i (al_uns),
    .addr_lo_i  (al_addr_lo),
    .wdata_i    (req_wdata_i),
    .rdata_i    (bus_rdata_i),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_rd_d    = rsp_rd_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
`ifdef LSU_MISALIGN_TRAP_EN
    rsp_err_d   = rsp_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && ready_q) begin
          we_d      = req_we_i;
          size_d    = req_size_i;
          uns_d     = req_unsigned_i;
          addr_lo_d = eff_addr[1:0];
          rd_d      = req_rd_i;
          if (trap_hit) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = 32'd0;
            rsp_rd_d    = req_we_i ? 5'd0 : req_rd_i;
`ifdef LSU_MISALIGN_TRAP_EN
            rsp_err_d   = 1'b1;
`endif
          end else begin
            state_d     = ST_BUS;
            bus_req_d   = 1'b1;
            bus_we_d    = req_we_i;
            bus_addr_d  = {eff_addr[31:2], 2'b00};
            bus_be_d    = al_be;
            bus_wdata_d = req_we_i ? al_wdata : 32'd0;
          end
        end
      end
      ST_BUS: begin
        if (bus_ack_i) begin
          state_d     = ST_RESP;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = 32'd0;
          bus_be_d    = 4'd0;
          bus_wdata_d = 32'd0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = we_q ? 32'd0 : al_rdata;
          rsp_rd_d    = we_q ? 5'd0 : rd_q;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        rsp_err_d   = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q     <= 1'b1;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_be_q    <= 4'd0;
      bus_wdata_q <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_rd_q    <= 5'd0;
      we_q        <= 1'b0;
      size_q      <= LSU_SIZE_B;
      uns_q       <= 1'b0;
      addr_lo_q   <= 2'd0;
      rd_q        <= 5'd0;
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      ready_q     <= ready_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_rd_q    <= rsp_rd_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_lo_q   <= addr_lo_d;
      rd_q        <= rd_d;
`ifdef LSU_MISALIGN_TRAP_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready_o = ready_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_rd_o    = rsp_rd_q;

endmodule
